// File: rtl/mem_stage_if.sv
// EX/MEM bundle into the memory stage, plus the stall and
// redirect signals it returns to the upstream stages.
interface mem_stage_if;
    logic        valid_in;
    logic [31:0] ir_in;
    logic [31:0] aluout_in;
    logic [31:0] rt_in;
    logic        zero_in;
    logic        jump_in;
    logic        branch_in;
    logic        RegWrite_in;
    logic        MemWrite_in;
    logic        MemRead_in;
    logic        MemtoReg_in;
    logic        stall;
    logic        branch_taken;
    logic        jump_taken;

    modport master (
        output valid_in, ir_in, aluout_in, rt_in,
        output zero_in, jump_in, branch_in,
        output RegWrite_in, MemWrite_in, MemRead_in, MemtoReg_in,
        input  stall, branch_taken, jump_taken
    );

    modport slave (
        input  valid_in, ir_in, aluout_in, rt_in,
        input  zero_in, jump_in, branch_in,
        input  RegWrite_in, MemWrite_in, MemRead_in, MemtoReg_in,
        output stall, branch_taken, jump_taken
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: word RAM with wait states, stall generation,
// branch/jump redirect and the MEM/WB pipeline register.
module mem_stage #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_stage_if.slave  ex,
    output logic [31:0] ir_wb,
    output logic [31:0] aluout_wb,
    output logic [31:0] memdata_wb,
    output logic        RegWrite_wb,
    output logic        MemtoReg_wb,
    output logic        wb_valid,
    output logic        misalign_err
);
    localparam int AW = $clog2(DEPTH);
    localparam bit HAS_WAIT = (WAIT_CYCLES > 0);
    localparam logic [3:0] CNT_INIT =
        HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t        state, state_nx;
    logic [3:0]    cnt, cnt_nx;
    logic          stall_c;
    logic          mem_op, aligned, need_wait;
    logic          is_store, is_load, wr_en;
    logic [AW-1:0] idx;
    logic [31:0]   rd_data;
    logic [31:0]   ram [DEPTH];

    assign mem_op    = ex.valid_in & (ex.MemRead_in | ex.MemWrite_in);
    assign aligned   = (ex.aluout_in[1:0] == 2'b00);
    assign need_wait = HAS_WAIT & mem_op & aligned;
    assign idx       = ex.aluout_in[AW+1:2];
    // A read+write request is treated as a store that returns zero.
    assign is_store  = mem_op & aligned & ex.MemWrite_in;
    assign is_load   = mem_op & aligned & ex.MemRead_in & ~ex.MemWrite_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            S_IDLE: begin
                if (need_wait) begin
                    state_nx = S_WAIT;
                    cnt_nx   = CNT_INIT;
                end
            end
            S_WAIT: begin
                if (cnt != 4'd0) cnt_nx = cnt - 4'd1;
                else             state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        stall_c = 1'b0;
        unique case (state)
            S_IDLE:  stall_c = need_wait;
            S_WAIT:  stall_c = (cnt != 4'd0);
            default: stall_c = 1'b0;
        endcase
    end

    assign ex.stall        = rst_n & stall_c;
    assign ex.branch_taken = ex.valid_in & ex.branch_in & ex.zero_in & ~ex.stall;
    assign ex.jump_taken   = ex.valid_in & ex.jump_in & ~ex.stall;

    // RAM has no reset; gating with rst_n drops a store abandoned by reset.
    assign wr_en   = rst_n & ~ex.stall & is_store;
    assign rd_data = ram[idx];

    always_ff @(posedge clk) begin
        if (wr_en) ram[idx] <= ex.rt_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_wb        <= '0;
            aluout_wb    <= '0;
            memdata_wb   <= '0;
            RegWrite_wb  <= 1'b0;
            MemtoReg_wb  <= 1'b0;
            wb_valid     <= 1'b0;
            misalign_err <= 1'b0;
        end else if (ex.stall) begin
            RegWrite_wb <= 1'b0;
            MemtoReg_wb <= 1'b0;
            wb_valid    <= 1'b0;
        end else begin
            ir_wb        <= ex.ir_in;
            aluout_wb    <= ex.aluout_in;
            memdata_wb   <= is_load ? rd_data : 32'd0;
            RegWrite_wb  <= ex.valid_in & ex.RegWrite_in;
            MemtoReg_wb  <= ex.valid_in & ex.MemtoReg_in;
            wb_valid     <= ex.valid_in;
            misalign_err <= misalign_err | (mem_op & ~aligned);
        end
    end
endmodule
